// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmitter and receiver.
//   OS_RATE  - os_tick pulses per bit period (16x oversampling).
//   ST_*     - transmitter FSM state encoding.
package uart_pkg;

    localparam int OS_RATE = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read data and occupancy count.
//   clk, rst          - clock, async active-high reset
//   wr_en, wr_data    - push request (ignored while full, even if a pop fires)
//   rd_en, rd_data    - pop request; rd_data always shows the head entry
//   count, full, empty- occupancy status
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;   // full blocks the push even when popping
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; stale entries are never visible past count.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_os16.sv
// uart_tx_os16: FIFO-buffered UART transmitter timed by a 16x oversample tick.
//   clk, rst            - clock, async active-high reset
//   os_tick             - 16x baud strobe, one clk wide
//   in_data/in_valid/in_ready - byte push handshake into the transmit FIFO
//   tx_line             - registered serial output, idles high
//   busy                - frame in progress or bytes queued
//   done                - one-clk pulse as each frame's last stop bit ends
//   fifo_count          - bytes currently queued
module uart_tx_os16 import uart_pkg::*; #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx_line,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        fifo_count
);

    localparam int TW = $clog2(OS_RATE * 2);
    localparam int BW = $clog2(DATA_BITS);

    logic [2:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_full, fifo_empty;
    logic                 pop;
    logic [TW-1:0]        last_tick;
    logic                 bit_end;

    assign in_ready = !fifo_full;
    assign busy     = (state != ST_IDLE) || (fifo_count != '0);

    // Stop period spans STOP_BITS bit times; every other state is one bit.
    assign last_tick = (state == ST_STOP) ? TW'(OS_RATE * STOP_BITS - 1)
                                          : TW'(OS_RATE - 1);
    assign bit_end   = os_tick && (tick_cnt == last_tick);

    // Pop from IDLE immediately, or at the end of STOP for back-to-back frames.
    assign pop = !fifo_empty &&
                 ((state == ST_IDLE) || (state == ST_STOP && bit_end));

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid && in_ready),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_line  <= 1'b1;
            done     <= 1'b0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
        end else begin
            done <= 1'b0;
            // Ticks only count inside a frame; IDLE ignores them.
            if (state != ST_IDLE && os_tick)
                tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);

            // Parity is captured at load time since shift is consumed bit by bit.
            if (pop) begin
                state    <= ST_START;
                tx_line  <= 1'b0;
                shift    <= head;
                par_bit  <= (^head) ^ (PARITY_ODD != 0);
                tick_cnt <= '0;
                bit_idx  <= '0;
            end

            case (state)
                ST_IDLE: ;
                ST_START: if (bit_end) begin
                    state   <= ST_DATA;
                    tx_line <= shift[0];
                end
                ST_DATA: if (bit_end) begin
                    if (bit_idx == BW'(DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            state   <= ST_PARITY;
                            tx_line <= par_bit;
                        end else begin
                            state   <= ST_STOP;
                            tx_line <= 1'b1;
                        end
                    end else begin
                        shift   <= shift >> 1;
                        tx_line <= shift[1];
                        bit_idx <= bit_idx + BW'(1);
                    end
                end
                ST_PARITY: if (bit_end) begin
                    state   <= ST_STOP;
                    tx_line <= 1'b1;
                end
                ST_STOP: if (bit_end) begin
                    done <= 1'b1;
                    if (fifo_empty) state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    tx_line <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_os16.md
UART_TX_OS16 -- requirements
Module: uart_tx_os16

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-002 Parameter FIFO_DEPTH, default 8: transmit FIFO entries, a power of two, at least 2.
REQ-003 Parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1: number of stop bits, 1 or 2.
REQ-006 clk  in  1  sole clock; all logic is on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 os_tick  in  1  one-clk-wide pulse at 16x the baud rate (same source as the receiver's os_tick).
REQ-009 in_data  in  DATA_BITS  byte to transmit; LSB is sent first.
REQ-010 in_valid  in  1  in_data is offered this cycle.
REQ-011 in_ready  out  1  FIFO can accept a byte this cycle.
REQ-012 tx_line  out  1  serial output; idles high.
REQ-013 busy  out  1  FIFO is non-empty or a frame is in progress.
REQ-014 done  out  1  one-clk pulse at the end of each frame's final stop bit.
REQ-015 fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes currently held in the FIFO.

Function
REQ-016 A byte SHALL be pushed on each clk edge where in_valid and in_ready are both high; in_ready = (fifo_count != FIFO_DEPTH).
REQ-017 When full, a push SHALL be refused even if a pop occurs in the same cycle; no write-through.
REQ-018 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave fifo_count unchanged and keep the data order.
REQ-019 FSM states are IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE, FIFO non-empty: pop the head into the shift register, reset the tick counter and bit index, and enter START; tx_line goes low on that same edge.
REQ-021 Each bit SHALL last exactly 16 os_ticks, counted from state entry; the transition happens on the clk edge that samples the 16th tick.
REQ-022 START (tx_line=0) -> DATA after 16 ticks.
REQ-023 DATA drives shift[0]; after each 16 ticks it shifts right and increments the bit index; after DATA_BITS bits it goes to PARITY if PARITY_EN, else STOP.
REQ-024 PARITY drives the XOR of all data bits, inverted when PARITY_ODD=1, then -> STOP.
REQ-025 STOP drives 1 for 16*STOP_BITS ticks; on its last tick it pulses done for one clk.
REQ-026 At the end of STOP, the FSM enters START directly (back-to-back, no idle gap) if the FIFO is non-empty, else IDLE.
REQ-027 os_tick pulses arriving in IDLE SHALL be ignored; frame start does not wait for a tick, so the start-bit phase is relative to the first tick after entry.
REQ-028 tx_line SHALL be driven from a register (glitch-free).
REQ-029 busy = (state != IDLE) || (fifo_count != 0), combinational from registered state.
REQ-030 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count saturates at neither bound because the handshake prevents overflow and underflow.
REQ-031 in_data is accepted only when the handshake fires; in_data and in_valid are don't-care otherwise.

Reset
REQ-032 While rst is high: state=IDLE, tx_line=1, done=0, in_ready=1, busy=0, fifo_count=0, FIFO pointers=0, tick and bit counters=0.
REQ-033 Reset asserted mid-frame SHALL force tx_line high immediately (asynchronously) and discard all queued bytes; no partial frame resumes after release.
REQ-034 The first push SHALL be accepted on the first clk edge after rst deasserts.

Structure
REQ-035 A shared package uart_pkg SHALL hold the FSM state encoding and the OS_RATE=16 constant; uart_rx_os16 SHALL import the same constant.
REQ-036 The FIFO SHALL be a separate sub-module, sync_fifo (parameterised width and depth, with count output); the FSM and shifter live in uart_tx_os16.

Verification
REQ-037 Push 0xB3 at 50 MHz with os_tick at 115200*16 into uart_rx_os16 -> rx_data=0xB3, valid pulse, framing_error=0, and exactly one done pulse.
REQ-038 os_tick every 4 clk; push 0x55 -> tx_line low for 64 clk, then 1,0,1,0,1,0,1,0 at 64 clk each, then high for 64 clk.
REQ-039 Push 0x01,0x02,0x03 back-to-back -> the three frames are contiguous, with no high gap beyond the stop bits, and there are 3 done pulses.
REQ-040 Hold in_valid high for 10 pushes while the line is busy -> in_ready drops at fifo_count=8; all 9 accepted bytes (8 queued + 1 popped) arrive in order.
REQ-041 PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, push 0x07 -> parity bit=1, followed by 32 ticks of stop; PARITY_ODD=1 gives parity bit 0.
REQ-042 Assert rst during the DATA state of the 2nd of 3 queued bytes -> tx_line=1 in the same cycle; fifo_count=0, busy=0; the receiver produces no valid after the line idles.
